adder_arbiter: RTL and testbench
================================

# adder_arbiter

Two-requester round-robin arbiter and sequencer sharing one WIDTH-bit adder.
- Each requester presents an operand pair over a valid/ready handshake.
- The block grants one requester per cycle, performs the add, and holds the registered sum, carry and requester ID in a one-deep output stage until the consumer accepts it.
- It sits between the top-level pin logic (operand sources) and the output drivers, replacing a direct combinational adder on the pins.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 operands valid.
- req0_ready  out  1  requester 0 granted and accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid  in  1  requester 1 operands valid.
- req1_ready  out  1  requester 1 granted and accepted this cycle.
- req1_a, req1_b  in  WIDTH  requester 1 operands.
- res_valid  out  1  result stage holds a result.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  registered sum.
- res_carry  out  1  carry-out / overflow of the add.
- res_id  out  1  ID of the requester that produced the result.
- ops_count  out  8  completed-accept counter, wraps 255→0.

## Operation
- Result stage state, encoded by res_valid: EMPTY (0) or FULL (1).
- can_accept = !res_valid || res_ready, so a full stage being drained the same cycle accepts a new operation.
- Arbitration, combinational:
  - Only one req valid: it is granted.
  - Both valid: the requester ≠ `last` is granted.
  - reqk_ready = can_accept && grant_k. Ready depends on valid; at most one ready is high per cycle.
- Handshake k = reqk_valid && reqk_ready. On handshake:
  - {res_carry, res_sum} ← reqk_a + reqk_b, computed at WIDTH+1 bits.
  - res_id ← k; res_valid ← 1; last ← k; ops_count ← ops_count+1.
- No handshake and res_ready && res_valid: res_valid ← 0. Data registers hold their last values.
- FULL && !res_ready: res_sum, res_carry and res_id are held stable; both req ready lines are 0.
- `last` updates only on a handshake, never on bare valid.
- Reset values: res_valid=0, res_sum=0, res_carry=0, res_id=0, ops_count=0, last=1 (requester 0 wins the first contention). req ready lines evaluate to their grant with res_valid=0.
- Reset mid-operation: a held result and any in-flight handshake are discarded immediately. Requesters must re-present.

## Timing
- Latency: handshake in cycle N → res_valid=1 with data from cycle N+1.
- Throughput: one add per cycle while res_ready=1.
- Both requesters continuously valid with res_ready=1: grants strictly alternate, 0,1,0,1…
- Simultaneous drain and accept: the result stage stays FULL with the new data. No bubble.
- Operand inputs are sampled only on the handshake edge; changes at other times have no effect.
- ops_count wraps 255→0 with no flag.

## Configuration
- ADDER_ARB_SAT_EN defined: unsigned saturation. When the WIDTH+1-bit sum overflows, res_sum ← all ones; res_carry still reports 1.
- ADDER_ARB_SAT_EN undefined: res_sum is the sum modulo 2^WIDTH (wrap), res_carry = bit WIDTH.
- Handshake, arbitration and timing are identical in both builds.

## Test plan
- Reset, then req0 a=0x12 b=0x34, res_ready=1 → next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=0, ops_count=1.
- Both requesters valid for 4 cycles, res_ready=1, req0 operands 1+1, req1 operands 2+2 → results 0x02(id0), 0x04(id1), 0x02(id0), 0x04(id1); ops_count=4.
- req1 a=0xF0 b=0x20 → default build: res_sum=0x10, res_carry=1. With ADDER_ARB_SAT_EN: res_sum=0xFF, res_carry=1.
- Backpressure: one result held with res_ready=0 for 3 cycles while both requesters are valid → both readys 0 and res_* stable. Raise res_ready → same cycle grants the requester ≠ last; new result appears next cycle with no bubble.
- Assert rst while FULL and both requesters valid → res_valid, res_sum and ops_count go to 0 before the next edge. After release, contention grants requester 0 first.
- 256 accepted operations → ops_count returns to 0.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester and result handshake bundle for adder_arbiter
interface adder_arbiter_if #(parameter int WIDTH = 8);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_id;
    logic [7:0]       ops_count;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, ops_count
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id, ops_count
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin arbiter sharing one adder, one-deep result stage.
// Define ADDER_ARB_SAT_EN for unsigned saturation of the sum on overflow.
module adder_arbiter #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    adder_arbiter_if.slave bus
);
    logic             valid_q, carry_q, id_q, last_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [7:0]       ops_q;
    logic             can_accept, grant0, grant1, hs, carry_d;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   raw;
    always_comb begin
        can_accept = !valid_q || bus.res_ready;
        // last_q names the previous winner; the other side wins a contention
        grant0     = bus.req0_valid && (!bus.req1_valid || last_q);
        grant1     = bus.req1_valid && (!bus.req0_valid || !last_q);
        hs         = can_accept && (grant0 || grant1);
        a          = grant1 ? bus.req1_a : bus.req0_a;
        b          = grant1 ? bus.req1_b : bus.req0_b;
        raw        = {1'b0, a} + {1'b0, b};
        carry_d    = raw[WIDTH];
`ifdef ADDER_ARB_SAT_EN
        sum_d      = raw[WIDTH] ? '1 : raw[WIDTH-1:0];
`else
        sum_d      = raw[WIDTH-1:0];
`endif
    end
    assign bus.req0_ready = can_accept && grant0;
    assign bus.req1_ready = can_accept && grant1;
    assign bus.res_valid  = valid_q;
    assign bus.res_sum    = sum_q;
    assign bus.res_carry  = carry_q;
    assign bus.res_id     = id_q;
    assign bus.ops_count  = ops_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            ops_q   <= 8'd0;
        end else if (hs) begin
            valid_q <= 1'b1;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= grant1;
            last_q  <= grant1;
            ops_q   <= ops_q + 8'd1;
        end else if (bus.res_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed-vector self-checking bench for adder_arbiter.
module tb_adder_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    adder_arbiter_if #(.WIDTH(8)) bus ();
    adder_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef ADDER_ARB_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'hFF;
`else
    localparam logic [7:0] OVF_SUM = 8'h10;
`endif
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic result(input string tag, input int v, input int s, input int c, input int id, input int ops);
        chk({tag, ".valid"}, int'(bus.res_valid), v);
        chk({tag, ".sum"},   int'(bus.res_sum),   s);
        chk({tag, ".carry"}, int'(bus.res_carry), c);
        chk({tag, ".id"},    int'(bus.res_id),    id);
        chk({tag, ".ops"},   int'(bus.ops_count), ops);
    endtask
    task automatic readies(input string tag, input int r0, input int r1);
        chk({tag, ".rdy0"}, int'(bus.req0_ready), r0);
        chk({tag, ".rdy1"}, int'(bus.req1_ready), r1);
    endtask
    initial begin
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.res_ready  = 1;
        #2;
        result("reset", 0, 0, 0, 0, 0);
        tick;
        rst = 0;
        // single request
        bus.req0_valid = 1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
        #1 readies("single", 1, 0);
        tick;
        bus.req0_valid = 0;
        result("single", 1, 8'h46, 0, 0, 1);
        tick;
        chk("drain.valid", int'(bus.res_valid), 0);
        // contention from reset: strict alternation starting with requester 0
        rst = 1; #1 rst = 0;
        bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 1;
        bus.req1_valid = 1; bus.req1_a = 2; bus.req1_b = 2;
        for (int i = 0; i < 4; i++) begin
            #1 readies($sformatf("alt%0d", i), (i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0);
            tick;
            result($sformatf("alt%0d", i), 1, (i % 2 == 1) ? 4 : 2, 0, i % 2, i + 1);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        // overflow
        bus.req1_valid = 1; bus.req1_a = 8'hF0; bus.req1_b = 8'h20;
        tick;
        result("ovf", 1, OVF_SUM, 1, 1, 5);
        // backpressure: result held, readys low, operands changed freely
        bus.res_ready = 0;
        bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 4;
        bus.req1_valid = 1; bus.req1_a = 5; bus.req1_b = 6;
        for (int i = 0; i < 3; i++) begin
            #1 readies($sformatf("bp%0d", i), 0, 0);
            tick;
            result($sformatf("bp%0d", i), 1, OVF_SUM, 1, 1, 5);
            bus.req1_a = 8'(8'h40 + i);
        end
        bus.req1_a = 5;
        bus.res_ready = 1;
        #1 readies("bp_release", 1, 0);
        tick;
        result("bp_new0", 1, 7, 0, 0, 6);
        #1 readies("bp_next", 0, 1);
        tick;
        result("bp_new1", 1, 8'h0B, 0, 1, 7);
        // asynchronous reset while full and both requesters valid
        bus.res_ready = 0;
        #2 rst = 1;
        #1 result("mid_rst", 0, 0, 0, 0, 0);
        #1 rst = 0;
        bus.res_ready = 1;
        #1 readies("post_rst", 1, 0);
        tick;
        result("post_rst", 1, 7, 0, 0, 1);
        // ops_count wrap
        bus.req1_valid = 0;
        rst = 1; #1 rst = 0;
        repeat (255) tick;
        chk("wrap.255", int'(bus.ops_count), 255);
        tick;
        chk("wrap.0", int'(bus.ops_count), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
